// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//   Operand forwarding and load-use hazard detection for the EX stage.
//   The EX instruction's source tags are compared against the destination
//   tags of DEPTH older producer slots (slot 1 = M, slot 2 = W, ...). Each
//   operand takes the youngest matching producer's data, or the RF value if
//   nothing matches. A stall is raised while the youngest match is a load
//   whose data has not yet reached slot LOAD_RDY.
//
//   Optional feature: define FWD_STALL_CNT_EN to build a 32-bit stall-cycle
//   counter on stall_cnt_o. Without it stall_cnt_o is tied to zero.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous reset, active low
//   id_valid_i    ID instruction valid
//   id_rs_i       ID source registers, op i at [i*REG_AW +: REG_AW]
//   id_rd_i       ID destination register
//   id_we_i       ID instruction writes rd
//   id_load_i     ID instruction is a load
//   flush_i       kill the EX and ID instructions
//   ex_rf_data_i  RF read data registered into EX, op i at [i*DATA_W +: DATA_W]
//   stage_data_i  producer slot k result at [(k-1)*DATA_W +: DATA_W]
//   ex_opnd_o     forwarded EX operands
//   ex_sel_o      per op: 0 = RF, k = producer slot k
//   ex_valid_o    EX holds a valid instruction
//   stall_o       load-use stall request to ID/EX
//   stall_cnt_o   stall-cycle count (zero unless FWD_STALL_CNT_EN)
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_OPS  = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_RDY = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid_i,
    input  logic [NUM_OPS*REG_AW-1:0]   id_rs_i,
    input  logic [REG_AW-1:0]           id_rd_i,
    input  logic                        id_we_i,
    input  logic                        id_load_i,
    input  logic                        flush_i,
    input  logic [NUM_OPS*DATA_W-1:0]   ex_rf_data_i,
    input  logic [DEPTH*DATA_W-1:0]     stage_data_i,
    output logic [NUM_OPS*DATA_W-1:0]   ex_opnd_o,
    output logic [NUM_OPS*$clog2(DEPTH+1)-1:0] ex_sel_o,
    output logic                        ex_valid_o,
    output logic                        stall_o,
    output logic [31:0]                 stall_cnt_o
);

    localparam int SEL_W = $clog2(DEPTH+1);

    // EX slot
    logic                       r_ex_valid;
    logic [NUM_OPS*REG_AW-1:0]  r_ex_rs;
    logic [REG_AW-1:0]          r_ex_rd;
    logic                       r_ex_we;
    logic                       r_ex_load;

    // Producer slots, index k-1 holds slot k
    logic [DEPTH-1:0]           r_slot_valid;
    logic [REG_AW-1:0]          r_slot_rd [DEPTH];
    logic [DEPTH-1:0]           r_slot_load;

    logic                       w_ex_prod;
    logic [SEL_W-1:0]           w_sel      [NUM_OPS];
    logic [DATA_W-1:0]          w_opnd     [NUM_OPS];
    logic [NUM_OPS-1:0]         w_op_stall;

    // Only instructions that really write a non-zero register become producers
    assign w_ex_prod = r_ex_valid & r_ex_we & (r_ex_rd != '0);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        for (int i = 0; i < NUM_OPS; i++) begin
            w_sel[i]      = '0;
            w_opnd[i]     = ex_rf_data_i[i*DATA_W +: DATA_W];
            w_op_stall[i] = 1'b0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (r_ex_valid && (r_ex_rs[i*REG_AW +: REG_AW] != '0) &&
                    r_slot_valid[k-1] &&
                    (r_slot_rd[k-1] == r_ex_rs[i*REG_AW +: REG_AW])) begin
                    w_sel[i]      = SEL_W'(k);
                    w_opnd[i]     = stage_data_i[(k-1)*DATA_W +: DATA_W];
                    w_op_stall[i] = r_slot_load[k-1] && (k < LOAD_RDY);
                end
            end
        end
    end

    assign stall_o    = |w_op_stall;
    assign ex_valid_o = r_ex_valid;

    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_out
            assign ex_sel_o[gi*SEL_W +: SEL_W]    = w_sel[gi];
            assign ex_opnd_o[gi*DATA_W +: DATA_W] = w_opnd[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_rs      <= '0;
            r_ex_rd      <= '0;
            r_ex_we      <= 1'b0;
            r_ex_load    <= 1'b0;
            r_slot_valid <= '0;
            r_slot_load  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_slot_rd[k] <= '0;
            end
        end else begin
            // Older slots always advance; a stall never blocks them, which is
            // what lets the pending load reach LOAD_RDY.
            for (int k = DEPTH-1; k >= 1; k--) begin
                r_slot_valid[k] <= r_slot_valid[k-1];
                r_slot_rd[k]    <= r_slot_rd[k-1];
                r_slot_load[k]  <= r_slot_load[k-1];
            end

            // A stalled EX instruction is held, so it must not also enter M.
            if (stall_o) begin
                r_slot_valid[0] <= 1'b0;
                r_slot_rd[0]    <= '0;
                r_slot_load[0]  <= 1'b0;
            end else begin
                r_slot_valid[0] <= w_ex_prod;
                r_slot_rd[0]    <= r_ex_rd;
                r_slot_load[0]  <= r_ex_load;
            end

            if (flush_i) begin
                r_ex_valid <= 1'b0;
                r_ex_rs    <= '0;
                r_ex_rd    <= '0;
                r_ex_we    <= 1'b0;
                r_ex_load  <= 1'b0;
            end else if (!stall_o) begin
                r_ex_valid <= id_valid_i;
                r_ex_rs    <= id_rs_i;
                r_ex_rd    <= id_rd_i;
                r_ex_we    <= id_we_i;
                r_ex_load  <= id_load_i;
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Flushed stall cycles are not counted; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall_o && !flush_i) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
